alu_writeback_buffer: RTL and testbench
=======================================

// Module: alu_writeback_buffer
// PURPOSE
//  Result-side consumer of the integer execution adder/ALU: captures each completed result (dest reg + value),
//  queues it in a small in-order FIFO and drains one entry per cycle into the register-file write port.
//  Decouples EX completion from register-file write availability; back-pressures EX via ex_ready.
// PARAMETERS
//  DATA_WIDTH   `DATA_WIDTH (32)  result width
//  REG_AW       5                 register address width (x0..x31)
//  DEPTH        4                 FIFO entries; power of two, >=2
// PORTS
//  clk        in   1           clock, all logic on posedge
//  reset      in   1           synchronous, active-low
//  ex_valid   in   1           EX presents a result this cycle
//  ex_ready   out  1           buffer can accept; transfer = ex_valid & ex_ready
//  ex_rd      in   REG_AW      destination register
//  ex_data    in   DATA_WIDTH  result value (e.g. add_value)
//  rf_we      out  1           register-file write strobe (head entry valid)
//  rf_waddr   out  REG_AW      head entry destination
//  rf_wdata   out  DATA_WIDTH  head entry data
//  rf_stall   in   1           RF port busy; head held, no pop
//  wb_count   out  log2(DEPTH)+1  occupancy
//  wb_empty   out  1           wb_count==0
//  fwd_raddr  in   REG_AW      forward lookup address (WB_FORWARD_EN only)
//  fwd_hit    out  1           lookup matched a buffered entry (WB_FORWARD_EN only)
//  fwd_data   out  DATA_WIDTH  matched data (WB_FORWARD_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): wr_ptr=rd_ptr=0, wb_count=0, all entry valids cleared; in-flight entries discarded.
//    While reset low: ex_ready=0, rf_we=0, fwd_hit=0; rf_waddr/rf_wdata/fwd_data=0. Pushes and pops ignored.
//  - Occupancy states: EMPTY (count 0), PARTIAL, FULL (count==DEPTH). ex_ready = !FULL (from registered count).
//  - Push: ex_valid & ex_ready -> entry {ex_rd, ex_data} written at wr_ptr, wr_ptr++ mod DEPTH.
//    ex_rd==0: handshake completes (ex_ready honoured) but nothing stored; count unchanged.
//  - Pop: rf_we = !EMPTY & reset; rf_waddr/rf_wdata show head combinationally from storage.
//    rf_we & !rf_stall -> rd_ptr++ mod DEPTH. rf_stall holds head and rf_we stable.
//  - Latency: result accepted at edge N appears on RF port in cycle N+1 (no same-cycle bypass to RF).
//  - Simultaneous push+pop: count unchanged, both pointers advance. When FULL, ex_ready=0 even if a pop
//    occurs that cycle (no push-through-full).
//  - Ordering strictly FIFO; pointers wrap silently; count never exceeds DEPTH nor underflows (asserted).
//  - Same rd buffered twice: both written in order; last write wins in RF.
// CONFIGURATION
//  Macro WB_FORWARD_EN:
//   defined   -> fwd_* ports exist. Combinational lookup over valid stored entries; youngest match wins;
//                fwd_raddr==0 never hits; entry being pushed this cycle not visible; entry being popped
//                this cycle still visible.
//   undefined -> fwd_* ports and compare logic absent; all other behaviour identical.
// STRUCTURE
//  - Shared header writeback_param.vh: WB_DEPTH default, REG_ADDR_WIDTH, WB_PTR_W (=log2 WB_DEPTH).
//    DATA_WIDTH taken from system_param.vh.
//  - One sub-module: wb_entry_ram (DEPTH x (REG_AW+DATA_WIDTH), 1 sync write, 1 async read port).
//    Pointers, count, handshake and forward compare stay in the top.
// TESTING
//  1 Reset: hold reset=0 3 cycles with ex_valid=1 -> ex_ready=0, rf_we=0, wb_count=0; release -> ex_ready=1.
//  2 Single pass: push rd=5,data=0x0000_00AA at edge N -> cycle N+1 rf_we=1,rf_waddr=5,rf_wdata=0xAA; empty at N+2.
//  3 Fill/stall: rf_stall=1, push 4 results (rd 1..4) -> wb_count=4, ex_ready=0; 5th ex_valid held, not lost;
//    drop rf_stall -> RF writes rd 1,2,3,4 in consecutive cycles, then 5th accepted.
//  4 x0 drop: push rd=0,data=0xDEAD -> handshake completes, wb_count stays 0, rf_we never asserted.
//  5 Wrap + simultaneous: stream 10 results with rf_stall toggling every other cycle -> RF sees all 10 in
//    order, count never >4, no duplicates.
//  6 WB_FORWARD_EN: buffer rd=7 data=1 then rd=7 data=2 under stall -> fwd_raddr=7 gives hit, 2; fwd_raddr=0 -> no hit;
//    mid-reset -> fwd_hit=0, buffer empty.

Source files
------------

// File: rtl/alu_writeback_buffer_pkg.sv
// alu_writeback_buffer_pkg: shared widths, entry layout and occupancy helper for the writeback buffer.
package alu_writeback_buffer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int REG_AW = 5;
  localparam int WB_DEPTH = 4;
  localparam int WB_PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = WB_PTR_W + 1;
  typedef struct packed {
    logic [REG_AW-1:0]     rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;
  function automatic occ_t occ_of(input logic [CNT_W-1:0] cnt);
    return cnt == '0 ? OCC_EMPTY : cnt == CNT_W'(WB_DEPTH) ? OCC_FULL : OCC_PARTIAL;
  endfunction
endpackage

// File: rtl/alu_writeback_buffer_if.sv
// alu_writeback_buffer_if: EX result handshake, register-file write port and optional forward lookup.
// The fwd_* signals exist only when WB_FORWARD_EN is defined.
interface alu_writeback_buffer_if;
  import alu_writeback_buffer_pkg::*;
  logic                  ex_valid;
  logic                  ex_ready;
  logic [REG_AW-1:0]     ex_rd;
  logic [DATA_WIDTH-1:0] ex_data;
  logic                  rf_we;
  logic [REG_AW-1:0]     rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  rf_stall;
  logic [CNT_W-1:0]      wb_count;
  logic                  wb_empty;
`ifdef WB_FORWARD_EN
  logic [REG_AW-1:0]     fwd_raddr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  modport master (
    output ex_valid, ex_rd, ex_data, rf_stall, fwd_raddr,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, wb_count, wb_empty, fwd_hit, fwd_data
  );
  modport slave (
    input  ex_valid, ex_rd, ex_data, rf_stall, fwd_raddr,
    output ex_ready, rf_we, rf_waddr, rf_wdata, wb_count, wb_empty, fwd_hit, fwd_data
  );
`else
  modport master (
    output ex_valid, ex_rd, ex_data, rf_stall,
    input  ex_ready, rf_we, rf_waddr, rf_wdata, wb_count, wb_empty
  );
  modport slave (
    input  ex_valid, ex_rd, ex_data, rf_stall,
    output ex_ready, rf_we, rf_waddr, rf_wdata, wb_count, wb_empty
  );
`endif
endinterface

// File: rtl/alu_writeback_buffer_wb_entry_ram.sv
// alu_writeback_buffer_wb_entry_ram: DEPTH x {rd,data} storage, one sync write, one async read.
// With WB_FORWARD_EN the whole array is also exposed for the forward compare.
module alu_writeback_buffer_wb_entry_ram
  import alu_writeback_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic [WB_PTR_W-1:0] waddr_i,
  input  entry_t              wentry_i,
  input  logic [WB_PTR_W-1:0] raddr_i,
`ifdef WB_FORWARD_EN
  output entry_t [WB_DEPTH-1:0] all_o,
`endif
  output entry_t              rentry_o
);
  entry_t [WB_DEPTH-1:0] mem_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wentry_i;
  assign rentry_o = mem_q[raddr_i];
`ifdef WB_FORWARD_EN
  assign all_o = mem_q;
`endif
endmodule

// File: rtl/alu_writeback_buffer.sv
// alu_writeback_buffer: in-order FIFO between EX results and the register-file write port.
// Define WB_FORWARD_EN to add a youngest-match forward lookup over buffered entries.
module alu_writeback_buffer
  import alu_writeback_buffer_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_writeback_buffer_if.slave wb
);
  logic [WB_PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  occ_t                occ;
  logic                push, store, pop;
  entry_t              head;
  assign occ         = occ_of(cnt_q);
  assign wb.ex_ready = reset && occ != OCC_FULL;
  assign push        = wb.ex_valid && wb.ex_ready;
  // x0 writes complete the handshake but are never buffered
  assign store       = push && wb.ex_rd != '0;
  assign wb.rf_we    = reset && occ != OCC_EMPTY;
  assign pop         = wb.rf_we && !wb.rf_stall;
  assign wb.rf_waddr = reset ? head.rd : '0;
  assign wb.rf_wdata = reset ? head.data : '0;
  assign wb.wb_count = cnt_q;
  assign wb.wb_empty = cnt_q == '0;
  always_comb begin
    wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(store) - CNT_W'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
`ifdef WB_FORWARD_EN
  entry_t [WB_DEPTH-1:0] ents;
  logic [WB_DEPTH-1:0]   vld_q, vld_d;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  always_comb begin
    vld_d = vld_q;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
    if (store) vld_d[wr_ptr_q] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) vld_q <= '0;
    else vld_q <= vld_d;
  end
  // scan oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (vld_q[rd_ptr_q + WB_PTR_W'(i)] && wb.fwd_raddr != '0 &&
          ents[rd_ptr_q + WB_PTR_W'(i)].rd == wb.fwd_raddr) begin
        hit      = 1'b1;
        hit_data = ents[rd_ptr_q + WB_PTR_W'(i)].data;
      end
    end
  end
  assign wb.fwd_hit  = reset && hit;
  assign wb.fwd_data = reset ? hit_data : '0;
`endif
  alu_writeback_buffer_wb_entry_ram u_wb_entry_ram (
    .clk      (clk),
    .we_i     (store),
    .waddr_i  (wr_ptr_q),
    .wentry_i ('{rd: wb.ex_rd, data: wb.ex_data}),
    .raddr_i  (rd_ptr_q),
`ifdef WB_FORWARD_EN
    .all_o    (ents),
`endif
    .rentry_o (head)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_W'(WB_DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && cnt_q == '0));
endmodule

// File: tb/tb_alu_writeback_buffer.sv
// tb_alu_writeback_buffer: directed self-checking bench for the writeback buffer.
// Forward-lookup checks are compiled in only when WB_FORWARD_EN is defined.
module tb_alu_writeback_buffer;
  import alu_writeback_buffer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vec = 0;
  int errs = 0;
  alu_writeback_buffer_if bus();
  alu_writeback_buffer dut (.clk(clk), .reset(reset), .wb(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd3;
    bus.ex_data  = 32'h1;
    bus.rf_stall = 1'b0;
`ifdef WB_FORWARD_EN
    bus.fwd_raddr = 5'd3;
`endif
    reset = 1'b0;
    repeat (3) tick();
    vec++; if (bus.ex_ready !== 1'b0) begin errs++; $display("FAIL reset_ex_ready got %b want 0", bus.ex_ready); end
    vec++; if (bus.rf_we !== 1'b0) begin errs++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
    vec++; if (bus.wb_count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d want 0", bus.wb_count); end
    vec++; if (bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin errs++; $display("FAIL reset_rf_port got %0d/%h want 0/0", bus.rf_waddr, bus.rf_wdata); end
`ifdef WB_FORWARD_EN
    vec++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin errs++; $display("FAIL reset_fwd got %b/%h want 0/0", bus.fwd_hit, bus.fwd_data); end
`endif
    bus.ex_valid = 1'b0;
    reset = 1'b1;
    #1;
    vec++; if (bus.ex_ready !== 1'b1) begin errs++; $display("FAIL release_ex_ready got %b want 1", bus.ex_ready); end
    vec++; if (bus.wb_empty !== 1'b1) begin errs++; $display("FAIL release_empty got %b want 1", bus.wb_empty); end
  endtask

  task automatic test_single();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd5;
    bus.ex_data  = 32'h0000_00AA;
    tick();
    bus.ex_valid = 1'b0;
    vec++; if (bus.rf_we !== 1'b1) begin errs++; $display("FAIL single_we got %b want 1", bus.rf_we); end
    vec++; if (bus.rf_waddr !== 5'd5) begin errs++; $display("FAIL single_waddr got %0d want 5", bus.rf_waddr); end
    vec++; if (bus.rf_wdata !== 32'hAA) begin errs++; $display("FAIL single_wdata got %h want 000000aa", bus.rf_wdata); end
    vec++; if (bus.wb_count !== 3'd1) begin errs++; $display("FAIL single_count got %0d want 1", bus.wb_count); end
    tick();
    vec++; if (bus.rf_we !== 1'b0 || bus.wb_empty !== 1'b1) begin errs++; $display("FAIL single_drain got we=%b empty=%b want 0/1", bus.rf_we, bus.wb_empty); end
  endtask

  task automatic test_fill_stall();
    logic [4:0] exp_rd [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    bus.rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'(i);
      bus.ex_data  = 32'(i * 32'h11);
      tick();
    end
    bus.ex_rd   = 5'd9;
    bus.ex_data = 32'h99;
    vec++; if (bus.wb_count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d want 4", bus.wb_count); end
    vec++; if (bus.ex_ready !== 1'b0) begin errs++; $display("FAIL fill_ex_ready got %b want 0", bus.ex_ready); end
    tick();
    vec++; if (bus.wb_count !== 3'd4 || bus.ex_ready !== 1'b0) begin errs++; $display("FAIL full_hold got count=%0d rdy=%b want 4/0", bus.wb_count, bus.ex_ready); end
    vec++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1) begin errs++; $display("FAIL stall_head got we=%b addr=%0d want 1/1", bus.rf_we, bus.rf_waddr); end
    bus.rf_stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_rd[k] || bus.rf_wdata !== 32'(exp_rd[k] * 32'h11)) begin
        errs++;
        $display("FAIL drain_%0d got we=%b addr=%0d data=%h want 1/%0d/%h", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_rd[k], 32'(exp_rd[k] * 32'h11));
      end
      if (k == 1) begin
        vec++; if (bus.ex_ready !== 1'b1) begin errs++; $display("FAIL refill_ready got %b want 1", bus.ex_ready); end
      end
      tick();
      if (k == 1) bus.ex_valid = 1'b0;
    end
    vec++; if (bus.wb_empty !== 1'b1 || bus.rf_we !== 1'b0) begin errs++; $display("FAIL fill_end got empty=%b we=%b want 1/0", bus.wb_empty, bus.rf_we); end
  endtask

  task automatic test_x0_drop();
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd0;
    bus.ex_data  = 32'hDEAD;
    vec++; if (bus.ex_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got %b want 1", bus.ex_ready); end
    tick();
    bus.ex_valid = 1'b0;
    vec++; if (bus.wb_count !== 3'd0 || bus.rf_we !== 1'b0) begin errs++; $display("FAIL x0_stored got count=%0d we=%b want 0/0", bus.wb_count, bus.rf_we); end
    tick();
    vec++; if (bus.rf_we !== 1'b0) begin errs++; $display("FAIL x0_we got %b want 0", bus.rf_we); end
  endtask

  task automatic test_stream();
    logic [REG_AW-1:0]     q_rd [$];
    logic [DATA_WIDTH-1:0] q_d [$];
    int sent = 0;
    int seen = 0;
    int cyc = 0;
    logic fp, fq;
    bus.rf_stall = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd10;
    bus.ex_data  = 32'h100;
    while ((sent < 10 || q_rd.size() != 0) && cyc < 100) begin
      fp = bus.ex_valid && bus.ex_ready;
      fq = bus.rf_we && !bus.rf_stall;
      if (fq) begin
        vec++;
        if (q_rd.size() == 0 || bus.rf_waddr !== q_rd[0] || bus.rf_wdata !== q_d[0]) begin
          errs++;
          $display("FAIL stream_write_%0d got %0d/%h want %0d/%h", seen, bus.rf_waddr, bus.rf_wdata, q_rd.size() ? q_rd[0] : 5'd0, q_d.size() ? q_d[0] : 32'd0);
        end
        if (q_rd.size() != 0) begin
          void'(q_rd.pop_front());
          void'(q_d.pop_front());
        end
        seen++;
      end
      if (fp) begin
        q_rd.push_back(bus.ex_rd);
        q_d.push_back(bus.ex_data);
        sent++;
      end
      tick();
      vec++;
      if (bus.wb_count !== CNT_W'(q_rd.size()) || bus.wb_count > 3'd4) begin
        errs++;
        $display("FAIL stream_count cycle %0d got %0d want %0d", cyc, bus.wb_count, q_rd.size());
      end
      if (fp) begin
        if (sent < 10) begin
          bus.ex_rd   = 5'(10 + sent);
          bus.ex_data = 32'(32'h100 + sent);
        end else bus.ex_valid = 1'b0;
      end
      bus.rf_stall = ~bus.rf_stall;
      cyc++;
    end
    bus.ex_valid = 1'b0;
    bus.rf_stall = 1'b0;
    vec++; if (seen != 10 || cyc >= 100) begin errs++; $display("FAIL stream_total got %0d writes in %0d cycles want 10 within 100", seen, cyc); end
    vec++; if (bus.wb_empty !== 1'b1) begin errs++; $display("FAIL stream_empty got %b want 1", bus.wb_empty); end
  endtask

  task automatic test_mid_reset();
    bus.rf_stall = 1'b1;
    bus.ex_valid = 1'b1;
    bus.ex_rd    = 5'd6;
    bus.ex_data  = 32'h66;
    tick();
    bus.ex_valid = 1'b0;
    vec++; if (bus.wb_count !== 3'd1) begin errs++; $display("FAIL midrst_pre got %0d want 1", bus.wb_count); end
    reset = 1'b0;
    #1;
    vec++; if (bus.rf_we !== 1'b0 || bus.ex_ready !== 1'b0 || bus.rf_wdata !== 32'd0) begin errs++; $display("FAIL midrst_outputs got we=%b rdy=%b data=%h want 0/0/0", bus.rf_we, bus.ex_ready, bus.rf_wdata); end
    tick();
    reset = 1'b1;
    bus.rf_stall = 1'b0;
    #1;
    vec++; if (bus.wb_empty !== 1'b1 || bus.rf_we !== 1'b0) begin errs++; $display("FAIL midrst_post got empty=%b we=%b want 1/0", bus.wb_empty, bus.rf_we); end
  endtask

`ifdef WB_FORWARD_EN
  task automatic test_forward();
    logic [4:0]  rds [3] = '{5'd7, 5'd7, 5'd3};
    logic [31:0] ds  [3] = '{32'd1, 32'd2, 32'd3};
    bus.rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ex_valid = 1'b1;
      bus.ex_rd    = rds[i];
      bus.ex_data  = ds[i];
      tick();
    end
    bus.ex_rd = 5'd8;
    bus.ex_data = 32'd8;
    bus.fwd_raddr = 5'd8;
    #1;
    vec++; if (bus.fwd_hit !== 1'b0) begin errs++; $display("FAIL fwd_pushing got %b want 0", bus.fwd_hit); end
    bus.fwd_raddr = 5'd7;
    #1;
    vec++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd2) begin errs++; $display("FAIL fwd_youngest got %b/%h want 1/2", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_raddr = 5'd3;
    #1;
    vec++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd3) begin errs++; $display("FAIL fwd_rd3 got %b/%h want 1/3", bus.fwd_hit, bus.fwd_data); end
    bus.fwd_raddr = 5'd0;
    #1;
    vec++; if (bus.fwd_hit !== 1'b0) begin errs++; $display("FAIL fwd_x0 got %b want 0", bus.fwd_hit); end
    tick();
    bus.ex_valid = 1'b0;
    bus.fwd_raddr = 5'd8;
    #1;
    vec++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd8) begin errs++; $display("FAIL fwd_rd8 got %b/%h want 1/8", bus.fwd_hit, bus.fwd_data); end
    bus.rf_stall = 1'b0;
    bus.fwd_raddr = 5'd7;
    #1;
    vec++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'd2) begin errs++; $display("FAIL fwd_popping got %b/%h want 1/2", bus.fwd_hit, bus.fwd_data); end
    bus.rf_stall = 1'b1;
    reset = 1'b0;
    #1;
    vec++; if (bus.fwd_hit !== 1'b0) begin errs++; $display("FAIL fwd_in_reset got %b want 0", bus.fwd_hit); end
    tick();
    reset = 1'b1;
    bus.rf_stall = 1'b0;
    #1;
    vec++; if (bus.fwd_hit !== 1'b0 || bus.wb_empty !== 1'b1) begin errs++; $display("FAIL fwd_after_reset got hit=%b empty=%b want 0/1", bus.fwd_hit, bus.wb_empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_x0_drop();
    test_stream();
    test_mid_reset();
`ifdef WB_FORWARD_EN
    test_forward();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
